// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - burst read sequencer for a 16x4 synchronous ROM
// Issues ROM reads, buffers returned nibbles in a small FIFO and streams them out with a running checksum.
module rom_burst_reader #(
    parameter int FIFO_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] start_addr,
    input  logic [4:0] len,
    output logic       rom_en,
    output logic [3:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic       out_valid,
    output logic [3:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic [3:0]      r_addr;
    logic [4:0]      r_remaining;
    logic            r_inflight;
    logic [3:0]      r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_sum;
    logic            r_done;

    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_last;
    logic [CW:0]     w_occupancy;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Space is reserved for the read already in flight, so issue depends only on registered state.
    assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue     = (r_state == S_RUN) && (r_remaining != 5'd0)
                         && (w_occupancy <= (CW + 1)'(FIFO_DEPTH - 1));
    assign w_push      = r_inflight;
    assign w_pop       = out_valid && out_ready;
    assign w_last      = (r_state == S_DRAIN) && w_pop && (r_count == CW'(1)) && !r_inflight;

    assign rom_en    = w_issue;
    assign rom_addr  = r_addr;
    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 4'h0;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign sum       = r_sum;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= 4'h0;
            r_remaining <= 5'd0;
            r_inflight  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_sum       <= 8'h00;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;

            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
                r_sum    <= r_sum + {4'h0, out_data};
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sum       <= 8'h00;
                        r_addr      <= start_addr;
                        r_remaining <= len;
                        if (len == 5'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + 4'd1;
                        r_remaining <= r_remaining - 5'd1;
                        if (r_remaining == 5'd1) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// tb/tb_rom_burst_reader.sv - self-checking bench for rom_burst_reader
// Drives bursts against a behavioural ROM and compares streams, addresses and sums with a reference model.
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] len;
    logic       rom_en;
    logic [3:0] rom_addr;
    logic [3:0] rom_data;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;

    int errors = 0;
    int checks = 0;

    rom_burst_reader #(.FIFO_DEPTH(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .sum        (sum)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rom_val(input int a);
        case (a % 16)
            0: return 4'h2;  1: return 4'h2;  2: return 4'hE;  3: return 4'h2;
            4: return 4'h6;  5: return 4'h3;  6: return 4'h8;  7: return 4'h6;
            8: return 4'h3;  9: return 4'h1;  10: return 4'hA; 11: return 4'h4;
            12: return 4'hA; 13: return 4'hF; 14: return 4'h2; default: return 4'h0;
        endcase
    endfunction

    // ROM output is undefined when not enabled, so a stray sample shows up as X.
    always @(posedge clk) begin
        rom_data <= rom_en ? rom_val(int'(rom_addr)) : 4'bxxxx;
    end

    function automatic int model_sum(input int a, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(rom_val(a + i));
        return s % 256;
    endfunction

    int  acc_q[$];
    int  iss_q[$];
    int  first_valid, last_acc_cyc, done_cnt, done_cyc, max_out;
    int  occ_viol, stall_viol;
    bit  busy_at_done, busy_at_last;

    task automatic run_burst(input logic [3:0] a, input logic [4:0] l, input int mode, input int inject_at);
        int  outstanding = 0;
        bit  stalled = 1'b0;
        logic [3:0] held = 4'h0;
        bit  acc;
        acc_q.delete(); iss_q.delete();
        first_valid = -1; last_acc_cyc = -1; done_cnt = 0; done_cyc = -1; max_out = 0;
        occ_viol = 0; stall_viol = 0; busy_at_done = 1'b1; busy_at_last = 1'b0;
        @(negedge clk);
        start = 1'b1; start_addr = a; len = l; out_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = (c % 7 == 0) || (c % 7 == 4) || (c % 7 == 6);
            else                out_ready = ($urandom_range(0, 9) < 7);
            if (c == inject_at) begin
                start = 1'b1; start_addr = ~a; len = 5'd7;
            end else begin
                start = 1'b0;
            end
            #1;
            if (stalled && (!out_valid || out_data !== held)) stall_viol++;
            if (outstanding > max_out) max_out = outstanding;
            if (rom_en) begin
                if (outstanding >= 3) occ_viol++;
                iss_q.push_back(int'(rom_addr));
            end
            if (out_valid && first_valid < 0) first_valid = c;
            acc = out_valid && out_ready;
            if (acc) begin
                acc_q.push_back(int'(out_data));
                last_acc_cyc = c;
                busy_at_last = busy;
            end
            outstanding += int'(rom_en) - int'(acc);
            stalled = out_valid && !out_ready;
            held = out_data;
            if (done) begin
                done_cnt++; done_cyc = c; busy_at_done = busy;
            end
            if (done_cnt > 0 && c > done_cyc + 2) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; start_addr = 4'h0; len = 5'd0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({rom_en, rom_addr, out_valid, out_data} !== 10'd0) begin
            errors++;
            $display("FAIL reset_rom_stream: got en=%b addr=%0d valid=%b data=%h, want all 0", rom_en, rom_addr, out_valid, out_data);
        end
        checks++;
        if ({busy, done, sum} !== 10'd0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b sum=%h, want all 0", busy, done, sum);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_data_bursts;
        int ta[4] = '{0, 14, 0, 0};
        int tl[4] = '{4, 4, 16, 17};
        int ts[4] = '{'h14, 'h06, 'h58, 'h5A};
        int bad;
        for (int k = 0; k < 4; k++) begin
            run_burst(4'(ta[k]), 5'(tl[k]), 0, -1);
            bad = (acc_q.size() != tl[k]) ? 1 : 0;
            for (int i = 0; i < acc_q.size() && i < tl[k]; i++)
                if (acc_q[i] != int'(rom_val(ta[k] + i))) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL burst%0d_beats: got %0d beats with %0d wrong, want %0d beats", k, acc_q.size(), bad, tl[k]);
            end
            bad = (iss_q.size() != tl[k]) ? 1 : 0;
            for (int i = 0; i < iss_q.size() && i < tl[k]; i++)
                if (iss_q[i] != (ta[k] + i) % 16) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL burst%0d_addrs: got %0d issues with %0d wrong, want %0d", k, iss_q.size(), bad, tl[k]);
            end
            checks++;
            if (sum !== 8'(ts[k])) begin
                errors++;
                $display("FAIL burst%0d_sum: got %h, want %h", k, sum, 8'(ts[k]));
            end
            checks++;
            if (first_valid != 2 || last_acc_cyc != tl[k] + 1) begin
                errors++;
                $display("FAIL burst%0d_timing: first_valid=%0d last_accept=%0d, want 2 and %0d", k, first_valid, last_acc_cyc, tl[k] + 1);
            end
            checks++;
            if (done_cnt != 1 || done_cyc != last_acc_cyc + 1 || busy_at_done || !busy_at_last) begin
                errors++;
                $display("FAIL burst%0d_done: count=%0d cycle=%0d busy_done=%b busy_last=%b, want 1 at %0d busy 0/1",
                         k, done_cnt, done_cyc, busy_at_done, busy_at_last, last_acc_cyc + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        int bad;
        logic [7:0] s_after;
        run_burst(4'd4, 5'd8, 1, -1);
        bad = (acc_q.size() != 8) ? 1 : 0;
        for (int i = 0; i < acc_q.size() && i < 8; i++)
            if (acc_q[i] != int'(rom_val(4 + i))) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats with %0d wrong, want 8 exact", acc_q.size(), bad);
        end
        checks++;
        if (max_out > 3 || occ_viol != 0) begin
            errors++;
            $display("FAIL bp_occupancy: max_buffered=%0d issue_when_full=%0d, want <=3 and 0", max_out, occ_viol);
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable stall cycles, want 0", stall_viol);
        end
        checks++;
        if (sum !== 8'(model_sum(4, 8)) || done_cnt != 1) begin
            errors++;
            $display("FAIL bp_sum_done: sum=%h done=%0d, want %h and 1", sum, done_cnt, 8'(model_sum(4, 8)));
        end
        s_after = 8'(model_sum(4, 8));
        repeat (3) @(negedge clk);
        checks++;
        if (sum !== s_after || busy !== 1'b0) begin
            errors++;
            $display("FAIL sum_hold: sum=%h busy=%b, want %h and 0", sum, busy, s_after);
        end
    endtask

    task automatic test_random;
        int a, l, bad;
        for (int k = 0; k < 6; k++) begin
            a = int'($urandom_range(0, 15));
            l = int'($urandom_range(1, 31));
            run_burst(4'(a), 5'(l), 2, -1);
            bad = (acc_q.size() != l) ? 1 : 0;
            for (int i = 0; i < acc_q.size() && i < l; i++)
                if (acc_q[i] != int'(rom_val(a + i))) bad++;
            for (int i = 0; i < iss_q.size() && i < l; i++)
                if (iss_q[i] != (a + i) % 16) bad++;
            if (iss_q.size() != l) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand%0d_stream: addr=%0d len=%0d beats=%0d issues=%0d wrong=%0d", k, a, l, acc_q.size(), iss_q.size(), bad);
            end
            checks++;
            if (sum !== 8'(model_sum(a, l)) || done_cnt != 1 || done_cyc != last_acc_cyc + 1 || occ_viol != 0 || stall_viol != 0) begin
                errors++;
                $display("FAIL rand%0d_status: sum=%h want %h done=%0d occ=%0d stall=%0d", k, sum, 8'(model_sum(a, l)), done_cnt, occ_viol, stall_viol);
            end
        end
    endtask

    task automatic test_len_zero;
        run_burst(4'd5, 5'd0, 0, -1);
        checks++;
        if (done_cnt != 1 || done_cyc != 0 || busy_at_done) begin
            errors++;
            $display("FAIL len0_done: count=%0d cycle=%0d busy=%b, want 1 at 0 busy 0", done_cnt, done_cyc, busy_at_done);
        end
        checks++;
        if (iss_q.size() != 0 || acc_q.size() != 0 || sum !== 8'h00) begin
            errors++;
            $display("FAIL len0_idle: issues=%0d beats=%0d sum=%h, want 0 0 00", iss_q.size(), acc_q.size(), sum);
        end
    endtask

    task automatic test_busy_start;
        int bad;
        run_burst(4'd2, 5'd6, 0, 3);
        bad = (acc_q.size() != 6 || iss_q.size() != 6) ? 1 : 0;
        for (int i = 0; i < acc_q.size() && i < 6; i++)
            if (acc_q[i] != int'(rom_val(2 + i))) bad++;
        checks++;
        if (bad != 0 || sum !== 8'(model_sum(2, 6)) || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start: beats=%0d issues=%0d wrong=%0d sum=%h done=%0d, want 6 6 0 %h 1",
                     acc_q.size(), iss_q.size(), bad, sum, done_cnt, 8'(model_sum(2, 6)));
        end
        checks++;
        if (busy !== 1'b0 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: busy=%b rom_en=%b, want 0 0", busy, rom_en);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        int bad;
        @(negedge clk);
        start = 1'b1; start_addr = 4'd1; len = 5'd10; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_en, rom_addr, out_valid, out_data, busy, done, sum} !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid: en=%b addr=%0d valid=%b data=%h busy=%b done=%b sum=%h, want all 0",
                     rom_en, rom_addr, out_valid, out_data, busy, done, sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_burst(4'd9, 5'd5, 0, -1);
        bad = (acc_q.size() != 5) ? 1 : 0;
        for (int i = 0; i < acc_q.size() && i < 5; i++)
            if (acc_q[i] != int'(rom_val(9 + i))) bad++;
        checks++;
        if (bad != 0 || first_valid != 2 || sum !== 8'(model_sum(9, 5))) begin
            errors++;
            $display("FAIL after_reset: beats=%0d wrong=%0d first_valid=%0d sum=%h, want 5 0 2 %h",
                     acc_q.size(), bad, first_valid, sum, 8'(model_sum(9, 5)));
        end
    endtask

    initial begin
        test_reset();
        test_data_bursts();
        test_backpressure();
        test_random();
        test_len_zero();
        test_busy_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
